// File: rtl/base_mem_bypass_mp.sv
`default_nettype none
// ============================================================================
// Module      : base_mem_bypass_mp
// Description : Multi-read-port RAM (one copy per read port, shared write)
//               with per-lane write-first bypass, programmable read latency
//               and optional forwarding of writes into in-flight reads.
// Revision    : 1.0 - initial release
// ============================================================================
module base_mem_bypass_mp #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 2**ADDR_WIDTH,
    parameter int NRD        = 2,
    parameter int LAT        = 2,
    parameter int LANES      = 4,
    parameter int FRESH      = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we,
    input  logic [LANES-1:0]          wbe,
    input  logic [ADDR_WIDTH-1:0]     wa,
    input  logic [WIDTH-1:0]          wd,
    input  logic [NRD-1:0]            re,
    input  logic [NRD*ADDR_WIDTH-1:0] ra,
    output logic [NRD*WIDTH-1:0]      rd,
    output logic [NRD-1:0]            rd_v
);

    localparam int                  c_lane_w = WIDTH / LANES;
    localparam logic [ADDR_WIDTH:0] c_depth  = (ADDR_WIDTH+1)'(DEPTH);

    logic [LANES-1:0] w_wmask;
    assign w_wmask = we ? wbe : '0;

    function automatic logic [WIDTH-1:0] lane_merge(
        input logic [WIDTH-1:0] old_d,
        input logic [WIDTH-1:0] new_d,
        input logic [LANES-1:0] mask
    );
        lane_merge = old_d;
        for (int l = 0; l < LANES; l++) begin
            if (mask[l]) lane_merge[l*c_lane_w +: c_lane_w] = new_d[l*c_lane_w +: c_lane_w];
        end
    endfunction

    assert property (@(posedge clk) disable iff (!reset) we |-> ({1'b0, wa} < c_depth));

    for (genvar p = 0; p < NRD; p++) begin : g_port
        logic [WIDTH-1:0]      r_mem [DEPTH];
        logic [ADDR_WIDTH-1:0] w_ra;
        logic [LANES-1:0]      w_hit0;
        logic [WIDTH-1:0]      w_rdata0;
        logic                  w_fin_v;
        logic [WIDTH-1:0]      w_fin_d;
        logic                  r_out_v;
        logic [WIDTH-1:0]      r_out_d;

        assign w_ra     = ra[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_hit0   = (wa == w_ra) ? w_wmask : '0;
        assign w_rdata0 = lane_merge(r_mem[w_ra], wd, w_hit0);

        assert property (@(posedge clk) disable iff (!reset) re[p] |-> ({1'b0, w_ra} < c_depth));

        always_ff @(posedge clk) begin
            for (int l = 0; l < LANES; l++) begin
                if (w_wmask[l]) r_mem[wa][l*c_lane_w +: c_lane_w] <= wd[l*c_lane_w +: c_lane_w];
            end
        end

        if (LAT == 1) begin : g_lat1
            assign w_fin_v = re[p];
            assign w_fin_d = w_rdata0;
        end else begin : g_latn
            // Stages 0..LAT-2; the output register acts as the final stage.
            logic [LAT-2:0]        r_pv;
            logic [WIDTH-1:0]      r_pd  [LAT-1];
            logic [ADDR_WIDTH-1:0] r_pa  [LAT-1];
            logic [WIDTH-1:0]      w_fwd [LAT-1];

            always_comb begin
                for (int k = 0; k < LAT-1; k++) begin
                    w_fwd[k] = (FRESH != 0) ?
                               lane_merge(r_pd[k], wd, (wa == r_pa[k]) ? w_wmask : '0) :
                               r_pd[k];
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_pv <= '0;
                end else begin
                    r_pv[0] <= re[p];
                    for (int k = 1; k < LAT-1; k++) r_pv[k] <= r_pv[k-1];
                end
            end

            always_ff @(posedge clk) begin
                if (re[p]) begin
                    r_pd[0] <= w_rdata0;
                    r_pa[0] <= w_ra;
                end
                for (int k = 1; k < LAT-1; k++) begin
                    if (r_pv[k-1]) begin
                        r_pd[k] <= w_fwd[k-1];
                        r_pa[k] <= r_pa[k-1];
                    end
                end
            end

            assign w_fin_v = r_pv[LAT-2];
            assign w_fin_d = w_fwd[LAT-2];
        end

        // Output data holds its last value between valid pulses.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_out_v <= 1'b0;
                r_out_d <= '0;
            end else begin
                r_out_v <= w_fin_v;
                if (w_fin_v) r_out_d <= w_fin_d;
            end
        end

        assign rd[p*WIDTH +: WIDTH] = r_out_d;
        assign rd_v[p]              = r_out_v;
    end

endmodule
`default_nettype wire
